// File: rtl/iob_dma_read_axi2axis_mb_if.sv
// AXI4 read-address and read-data channels of the DMA read master.
interface iob_dma_read_axi2axis_mb_if #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32,
  parameter int unsigned LEN_W  = 8,
  parameter int unsigned ID_W   = 1
);
  logic [ADDR_W-1:0] araddr;
  logic              arvalid;
  logic              arready;
  logic [LEN_W-1:0]  arlen;
  logic [2:0]        arsize;
  logic [1:0]        arburst;
  logic [ID_W-1:0]   arid;
  logic              arlock;
  logic [3:0]        arcache;
  logic [2:0]        arprot;
  logic [3:0]        arqos;

  logic [DATA_W-1:0] rdata;
  logic [1:0]        rresp;
  logic              rlast;
  logic              rvalid;
  logic [ID_W-1:0]   rid;
  logic              rready;

  modport master (
    output araddr, arvalid, arlen, arsize, arburst, arid, arlock, arcache, arprot, arqos, rready,
    input  arready, rdata, rresp, rlast, rvalid, rid
  );

  modport slave (
    input  araddr, arvalid, arlen, arsize, arburst, arid, arlock, arcache, arprot, arqos, rready,
    output arready, rdata, rresp, rlast, rvalid, rid
  );
endinterface

// File: rtl/iob_dma_read_axi2axis_mb.sv
// AXI4 read master that splits a beat-counted transfer into 4 KiB-safe INCR bursts
// and forwards the read data to an AXI-Stream through a 2-entry buffer.
module iob_dma_read_axi2axis_mb #(
  parameter int unsigned AXI_ADDR_W    = 32,
  parameter int unsigned AXI_DATA_W    = 32,
  parameter int unsigned AXI_LEN_W     = 8,
  parameter int unsigned AXI_ID_W      = 1,
  parameter int unsigned MAX_BURST_LEN = 256,
  parameter int unsigned LENGTH_W      = 16
) (
  input  logic                      clk_i,
  input  logic                      cke_i,
  input  logic                      rst_n_i,
  iob_dma_read_axi2axis_mb_if.master axi,
  input  logic [AXI_ADDR_W-1:0]     r_addr_i,
  input  logic [LENGTH_W-1:0]       r_length_i,
  input  logic                      r_start_transfer_i,
  output logic                      r_busy_o,
  output logic                      r_error_o,
  output logic [AXI_DATA_W-1:0]     axis_out_data_o,
  output logic                      axis_out_valid_o,
  input  logic                      axis_out_ready_i,
  output logic                      axis_out_last_o
);
  localparam int unsigned BYTES  = AXI_DATA_W / 8;
  localparam int unsigned OFFS_W = $clog2(BYTES);
  // wide enough for the transfer length and for the 4 KiB page room in beats
  localparam int unsigned CALC_W = (LENGTH_W + 1 > 14) ? LENGTH_W + 1 : 14;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ADDR  = 2'd1;
  localparam logic [1:0] S_DATA  = 2'd2;
  localparam logic [1:0] S_DRAIN = 2'd3;

  typedef struct packed {
    logic                  last;
    logic [AXI_DATA_W-1:0] data;
  } beat_t;

  logic [1:0]            state_q, state_n;
  logic [AXI_ADDR_W-1:0] addr_q, addr_n;
  logic [LENGTH_W-1:0]   rem_q, rem_n;
  logic [CALC_W-1:0]     burst_q, burst_n;
  logic [AXI_LEN_W-1:0]  arlen_q, arlen_n;
  logic                  arvalid_q, arvalid_n;
  logic                  rready_q, rready_n;
  logic                  err_q, err_n;
  logic                  busy_q, busy_n;
  logic                  valid_q, valid_n;
  logic [1:0]            cnt_q, cnt_n;
  beat_t                 slot0_q, slot0_n;
  beat_t                 slot1_q, slot1_n;
  beat_t                 in_beat;
  logic                  push;
  logic                  pop;

  // Beats in the next burst: limited by what is left, the burst cap and the 4 KiB page end.
  function automatic logic [CALC_W-1:0] calc_burst(input logic [AXI_ADDR_W-1:0] a,
                                                   input logic [LENGTH_W-1:0]   rem);
    logic [12:0]       room_bytes;
    logic [CALC_W-1:0] room;
    logic [CALC_W-1:0] b;
    room_bytes = 13'h1000 - {1'b0, a[11:0]};
    room       = CALC_W'(room_bytes >> OFFS_W);
    b          = CALC_W'(rem);
    if (b > CALC_W'(MAX_BURST_LEN)) b = CALC_W'(MAX_BURST_LEN);
    if (b > room) b = room;
    return b;
  endfunction

  always_comb begin
    state_n   = state_q;
    addr_n    = addr_q;
    rem_n     = rem_q;
    burst_n   = burst_q;
    arlen_n   = arlen_q;
    arvalid_n = arvalid_q;
    err_n     = err_q;
    slot0_n   = slot0_q;
    slot1_n   = slot1_q;
    cnt_n     = cnt_q;
    push      = 1'b0;
    pop       = valid_q && axis_out_ready_i;
    in_beat.data = axi.rdata;
    in_beat.last = axi.rlast && (rem_q == '0);

    case (state_q)
      S_IDLE: begin
        if (r_start_transfer_i && (r_length_i != '0)) begin
          addr_n    = r_addr_i & ~AXI_ADDR_W'(BYTES - 1);
          rem_n     = r_length_i;
          burst_n   = calc_burst(addr_n, r_length_i);
          arlen_n   = AXI_LEN_W'(burst_n - CALC_W'(1));
          arvalid_n = 1'b1;
          err_n     = 1'b0;
          state_n   = S_ADDR;
        end
      end
      S_ADDR: begin
        if (axi.arready) begin
          arvalid_n = 1'b0;
          rem_n     = rem_q - LENGTH_W'(burst_q);
          state_n   = S_DATA;
        end
      end
      S_DATA: begin
        if (axi.rvalid && rready_q) begin
          push = 1'b1;
          if (axi.rresp != 2'b00) err_n = 1'b1;
          // bursts are delimited by rlast alone; beats are not counted
          if (axi.rlast) begin
            if (rem_q != '0) begin
              addr_n    = addr_q + (AXI_ADDR_W'(burst_q) << OFFS_W);
              burst_n   = calc_burst(addr_n, rem_q);
              arlen_n   = AXI_LEN_W'(burst_n - CALC_W'(1));
              arvalid_n = 1'b1;
              state_n   = S_ADDR;
            end else begin
              state_n = S_DRAIN;
            end
          end
        end
      end
      S_DRAIN: begin
        if (pop && slot0_q.last) state_n = S_IDLE;
      end
      default: state_n = S_IDLE;
    endcase

    // slot0 is always the head; slot1 only ever holds the second entry
    case ({push, pop})
      2'b10: begin
        if (cnt_q == 2'd0) slot0_n = in_beat;
        else               slot1_n = in_beat;
        cnt_n = cnt_q + 2'd1;
      end
      2'b01: begin
        slot0_n = slot1_q;
        cnt_n   = cnt_q - 2'd1;
      end
      2'b11: begin
        if (cnt_q == 2'd1) begin
          slot0_n = in_beat;
        end else begin
          slot0_n = slot1_q;
          slot1_n = in_beat;
        end
      end
      default: ;
    endcase

    rready_n = (state_n == S_DATA) && (cnt_n != 2'd2);
    valid_n  = (cnt_n != 2'd0);
    busy_n   = (state_n != S_IDLE);
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      state_q   <= S_IDLE;
      addr_q    <= '0;
      rem_q     <= '0;
      burst_q   <= '0;
      arlen_q   <= '0;
      arvalid_q <= 1'b0;
      rready_q  <= 1'b0;
      err_q     <= 1'b0;
      busy_q    <= 1'b0;
      valid_q   <= 1'b0;
      cnt_q     <= 2'd0;
      slot0_q   <= '0;
      slot1_q   <= '0;
    end else if (cke_i) begin
      state_q   <= state_n;
      addr_q    <= addr_n;
      rem_q     <= rem_n;
      burst_q   <= burst_n;
      arlen_q   <= arlen_n;
      arvalid_q <= arvalid_n;
      rready_q  <= rready_n;
      err_q     <= err_n;
      busy_q    <= busy_n;
      valid_q   <= valid_n;
      cnt_q     <= cnt_n;
      slot0_q   <= slot0_n;
      slot1_q   <= slot1_n;
    end
  end

  assign axi.araddr  = addr_q;
  assign axi.arvalid = arvalid_q;
  assign axi.arlen   = arlen_q;
  assign axi.arsize  = 3'(OFFS_W);
  assign axi.arburst = 2'b01;
  assign axi.arid    = AXI_ID_W'(0);
  assign axi.arlock  = 1'b0;
  assign axi.arcache = 4'b0010;
  assign axi.arprot  = 3'b010;
  assign axi.arqos   = 4'b0000;
  assign axi.rready  = rready_q;

  assign axis_out_data_o  = slot0_q.data;
  assign axis_out_last_o  = slot0_q.last;
  assign axis_out_valid_o = valid_q;
  assign r_busy_o         = busy_q;
  assign r_error_o        = err_q;
endmodule

// File: tb/tb_iob_dma_read_axi2axis_mb.sv
// Bench for the DMA read AXI-to-stream converter: AXI slave model, stream sink and
// scoreboards for AR requests and stream beats, driven from a vector table.
module tb_iob_dma_read_axi2axis_mb;
  localparam int unsigned AW   = 32;
  localparam int unsigned DW   = 32;
  localparam int unsigned LW   = 8;
  localparam int unsigned IW   = 1;
  localparam int unsigned LENW = 16;
  localparam int          NV   = 8;

  typedef struct packed {
    logic [31:0] addr;
    logic [7:0]  len;
  } ar_t;

  typedef struct packed {
    logic [31:0] data;
    logic        last;
  } beat_t;

  typedef struct packed {
    logic [31:0]      addr;
    logic [15:0]      len;
    logic [1:0]       n_ar;
    logic [2:0][31:0] ar_addr;
    logic [2:0][7:0]  ar_len;
    logic             rand_rdy;
    logic [7:0]       err_at;
    logic             poke;
  } vec_t;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            cke;
  logic [AW-1:0]   r_addr;
  logic [LENW-1:0] r_length;
  logic            r_start;
  logic            r_busy;
  logic            r_error;
  logic [DW-1:0]   s_data;
  logic            s_valid;
  logic            s_ready;
  logic            s_last;

  iob_dma_read_axi2axis_mb_if #(.ADDR_W(AW), .DATA_W(DW), .LEN_W(LW), .ID_W(IW)) axi ();

  iob_dma_read_axi2axis_mb #(
    .AXI_ADDR_W(AW), .AXI_DATA_W(DW), .AXI_LEN_W(LW), .AXI_ID_W(IW),
    .MAX_BURST_LEN(256), .LENGTH_W(LENW)
  ) dut (
    .clk_i(clk), .cke_i(cke), .rst_n_i(rst_n), .axi(axi),
    .r_addr_i(r_addr), .r_length_i(r_length), .r_start_transfer_i(r_start),
    .r_busy_o(r_busy), .r_error_o(r_error),
    .axis_out_data_o(s_data), .axis_out_valid_o(s_valid),
    .axis_out_ready_i(s_ready), .axis_out_last_o(s_last)
  );

  always #5 clk = ~clk;

  int    checks = 0;
  int    failures = 0;
  int    tid = 0;
  int    cnt = 0;
  int    xfer_beat = 0;
  int    r_beat = 0;
  bit    abort, done, rand_rdy, saw_arvalid;
  bit    r_acc, r_active, err_chk, busy_chk, ar_wait, push_d, pop_d;
  logic [7:0] err_at = 8'hFF;
  ar_t   cur, w_ar, ea;
  beat_t eb;
  ar_t   exp_ar_q[$];
  ar_t   ar_q[$];
  beat_t exp_q[$];
  vec_t  vecs[NV];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'hA5C3_0000 ^ (32'(tid) << 24);
  endfunction

  function automatic vec_t mk(input logic [31:0] a, input logic [15:0] l, input logic [1:0] n,
                              input logic [31:0] a0, input logic [7:0] l0,
                              input logic [31:0] a1, input logic [7:0] l1,
                              input logic [31:0] a2, input logic [7:0] l2,
                              input logic rr, input logic [7:0] ea_i, input logic pk);
    vec_t v;
    v.addr = a; v.len = l; v.n_ar = n;
    v.ar_addr[0] = a0; v.ar_len[0] = l0;
    v.ar_addr[1] = a1; v.ar_len[1] = l1;
    v.ar_addr[2] = a2; v.ar_len[2] = l2;
    v.rand_rdy = rr; v.err_at = ea_i; v.poke = pk;
    return v;
  endfunction

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_arvalid"}, axi.arvalid, 0);
    chk({tag, "_araddr"},  axi.araddr, 0);
    chk({tag, "_arlen"},   axi.arlen, 0);
    chk({tag, "_rready"},  axi.rready, 0);
    chk({tag, "_svalid"},  s_valid, 0);
    chk({tag, "_sdata"},   s_data, 0);
    chk({tag, "_slast"},   s_last, 0);
    chk({tag, "_busy"},    r_busy, 0);
    chk({tag, "_error"},   r_error, 0);
  endtask

  // AXI slave, stream sink and buffer-occupancy model; decisions for the coming edge
  always @(negedge clk) begin
    if (abort) begin
      axi.arready = 1'b0; axi.rvalid = 1'b0; axi.rlast = 1'b0; axi.rresp = 2'd0; axi.rdata = '0;
      s_ready = 1'b0;
      ar_q.delete(); exp_q.delete(); exp_ar_q.delete();
      r_active = 0; r_acc = 0; cnt = 0; err_chk = 0; busy_chk = 0; ar_wait = 0;
    end else begin
      if (err_chk) chk("error_next_cycle", r_error, 1);
      err_chk = 0;
      if (busy_chk) chk("busy_fall", r_busy, 0);
      busy_chk = 0;
      if (ar_wait) begin
        chk("ar_hold_valid", axi.arvalid, 1);
        chk("ar_hold_addr", axi.araddr, w_ar.addr);
        chk("ar_hold_len", axi.arlen, w_ar.len);
      end
      ar_wait = 0;
      if (axi.arvalid) saw_arvalid = 1;
      chk("axis_valid_vs_count", s_valid, cnt != 0);
      if (cnt == 2) chk("rready_low_when_full", axi.rready, 0);

      // R channel: one beat at a time, held until accepted
      if (r_acc) begin axi.rvalid = 1'b0; r_acc = 0; end
      if (!r_active && ar_q.size() != 0) begin
        cur = ar_q.pop_front(); r_active = 1; r_beat = 0;
      end
      if (r_active && !axi.rvalid && (!rand_rdy || $urandom_range(0, 3) != 0)) begin
        axi.rvalid = 1'b1;
        axi.rdata  = mem_word(cur.addr + 32'(4 * r_beat));
        axi.rlast  = (r_beat == int'(cur.len));
        axi.rresp  = (err_at != 8'hFF && xfer_beat == int'(err_at)) ? 2'd2 : 2'd0;
      end
      push_d = 0;
      if (axi.rvalid && axi.rready) begin
        push_d = 1; r_acc = 1; xfer_beat++;
        if (axi.rresp != 2'd0) err_chk = 1;
        if (axi.rlast) r_active = 0;
        else r_beat++;
      end

      // AR channel
      axi.arready = ($urandom_range(0, 1) == 1);
      if (axi.arvalid) begin
        if (axi.arready) begin
          chk("arsize", axi.arsize, 2);
          chk("arburst", axi.arburst, 1);
          chk("arcache", axi.arcache, 2);
          chk("arprot", axi.arprot, 2);
          chk("arid_lock_qos", {axi.arid, axi.arlock, axi.arqos}, 0);
          if (exp_ar_q.size() == 0) begin
            checks++; failures++;
            $display("FAIL ar_unexpected actual=0x%0h/%0d required=none", axi.araddr, axi.arlen);
          end else begin
            ea = exp_ar_q.pop_front();
            chk("ar_addr", axi.araddr, ea.addr);
            chk("ar_len", axi.arlen, ea.len);
          end
          ar_q.push_back('{addr: axi.araddr, len: axi.arlen});
        end else begin
          ar_wait = 1; w_ar = '{addr: axi.araddr, len: axi.arlen};
        end
      end

      // stream sink against the beat scoreboard
      s_ready = rand_rdy ? ($urandom_range(0, 1) == 1) : 1'b1;
      pop_d = 0;
      if (s_valid && s_ready) begin
        pop_d = 1;
        if (exp_q.size() == 0) begin
          checks++; failures++;
          $display("FAIL stream_extra_beat actual=0x%0h required=none", s_data);
        end else begin
          eb = exp_q.pop_front();
          chk("stream_data", s_data, eb.data);
          chk("stream_last", s_last, eb.last);
          if (eb.last) begin done = 1; busy_chk = 1; end
        end
      end
      cnt = cnt + int'(push_d) - int'(pop_d);
    end
  end

  task automatic load_expect(input vec_t v);
    logic [31:0] base;
    tid++;
    base = v.addr & ~32'h3;
    for (int k = 0; k < int'(v.n_ar); k++)
      exp_ar_q.push_back('{addr: v.ar_addr[k], len: v.ar_len[k]});
    for (int k = 0; k < int'(v.len); k++)
      exp_q.push_back('{data: mem_word(base + 32'(4 * k)), last: (k == int'(v.len) - 1)});
    rand_rdy = v.rand_rdy; err_at = v.err_at; xfer_beat = 0; done = 0;
  endtask

  task automatic run_vec(input vec_t v);
    int c;
    load_expect(v);
    r_addr = v.addr; r_length = v.len; r_start = 1'b1;
    @(negedge clk); r_start = 1'b0;
    chk("busy_after_start", r_busy, 1);
    chk("arvalid_after_start", axi.arvalid, 1);
    chk("error_cleared_on_start", r_error, 0);
    if (v.poke) begin
      repeat (30) @(negedge clk);
      r_addr = 32'h9000; r_length = 16'd5; r_start = 1'b1;
      @(negedge clk); r_start = 1'b0;
      chk("busy_during_poke", r_busy, 1);
    end
    c = 0;
    while (!done && c < 20000) begin @(negedge clk); c++; end
    chk("xfer_done", done, 1);
    repeat (3) @(negedge clk);
    chk("beats_left", exp_q.size(), 0);
    chk("ars_left", exp_ar_q.size(), 0);
    chk("error_flag_end", r_error, v.err_at != 8'hFF);
    chk("busy_idle", r_busy, 0);
  endtask

  initial begin
    int c;
    rst_n = 1'b0; cke = 1'b1; abort = 1; r_start = 1'b0; r_addr = '0; r_length = '0;
    axi.rid = '0; s_ready = 1'b0; rand_rdy = 0; saw_arvalid = 0; done = 0;
    vecs[0] = mk(32'h1000, 16'd16, 2'd1, 32'h1000, 8'd15, 32'h0, 8'd0, 32'h0, 8'd0, 1'b0, 8'hFF, 1'b0);
    vecs[1] = mk(32'h0FF0, 16'd8, 2'd2, 32'h0FF0, 8'd3, 32'h1000, 8'd3, 32'h0, 8'd0, 1'b0, 8'hFF, 1'b0);
    vecs[2] = mk(32'h0000, 16'd600, 2'd3, 32'h000, 8'd255, 32'h400, 8'd255, 32'h800, 8'd87, 1'b0, 8'hFF, 1'b1);
    vecs[3] = mk(32'h3000, 16'd40, 2'd1, 32'h3000, 8'd39, 32'h0, 8'd0, 32'h0, 8'd0, 1'b1, 8'hFF, 1'b0);
    vecs[4] = mk(32'h4000, 16'd8, 2'd1, 32'h4000, 8'd7, 32'h0, 8'd0, 32'h0, 8'd0, 1'b0, 8'd2, 1'b0);
    vecs[5] = mk(32'h2003, 16'd3, 2'd1, 32'h2000, 8'd2, 32'h0, 8'd0, 32'h0, 8'd0, 1'b0, 8'hFF, 1'b0);
    vecs[6] = mk(32'h0FFC, 16'd2, 2'd2, 32'h0FFC, 8'd0, 32'h1000, 8'd0, 32'h0, 8'd0, 1'b0, 8'hFF, 1'b0);
    vecs[7] = mk(32'h7FF8, 16'd5, 2'd2, 32'h7FF8, 8'd1, 32'h8000, 8'd2, 32'h0, 8'd0, 1'b1, 8'hFF, 1'b0);

    repeat (3) @(negedge clk);
    check_reset_outputs("rst");
    rst_n = 1'b1;
    @(negedge clk); abort = 0;

    for (int i = 0; i < NV; i++) run_vec(vecs[i]);

    // zero-length start must not touch the bus
    saw_arvalid = 0;
    r_addr = 32'h5000; r_length = 16'd0; r_start = 1'b1;
    @(negedge clk); r_start = 1'b0;
    chk("len0_busy_next", r_busy, 0);
    repeat (8) @(negedge clk);
    chk("len0_no_arvalid", saw_arvalid, 0);
    chk("len0_busy", r_busy, 0);

    // registers hold while the clock enable is low
    cke = 1'b0; r_addr = 32'h6000; r_length = 16'd4; r_start = 1'b1;
    repeat (2) @(negedge clk);
    chk("cke_low_busy", r_busy, 0);
    chk("cke_low_arvalid", axi.arvalid, 0);
    r_start = 1'b0; cke = 1'b1;
    @(negedge clk);
    chk("cke_restore_busy", r_busy, 0);

    // reset in the middle of a transfer that has already flagged an error
    load_expect(mk(32'h5000, 16'd10, 2'd1, 32'h5000, 8'd9, 32'h0, 8'd0, 32'h0, 8'd0, 1'b0, 8'd1, 1'b0));
    r_addr = 32'h5000; r_length = 16'd10; r_start = 1'b1;
    @(negedge clk); r_start = 1'b0;
    c = 0;
    while (xfer_beat < 5 && c < 200) begin @(negedge clk); c++; end
    chk("mid_beat5_reached", xfer_beat >= 5, 1);
    chk("mid_error_set", r_error, 1);
    chk("mid_busy", r_busy, 1);
    rst_n = 1'b0; abort = 1;
    @(negedge clk);
    check_reset_outputs("mid_rst");
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk); abort = 0;

    run_vec(vecs[1]);
    run_vec(vecs[0]);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
